// File: rtl/spi3w_pkg.sv
// Shared types and helpers for the 3-wire SPI slave register map.
// Optional feature macro: SPI3W_PARITY_EN (adds an even-parity bit to every data word).
package spi3w_pkg;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_TURN,
      ST_RDATA
   } spi3w_state_t;

`ifdef SPI3W_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   // Bits per data word on the wire: payload plus optional parity bit.
   function automatic int word_len(input int data_w);
      return data_w + (PAR_EN ? 1 : 0);
   endfunction

endpackage

// File: rtl/spi3w_regfile.sv
// Register array with one write port, one combinational read port and a flat view of all words.
// Addresses at or above NUM_REGS match no word: writes are ignored and reads return zero.
module spi3w_regfile
   import spi3w_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 7,
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       NUM_REGS  = 2 ** ADDR_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [ADDR_W-1:0]          raddr,
   output logic [DATA_W-1:0]          rdata,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

   logic [NUM_REGS*DATA_W-1:0] regs_q;

   // Storage: synchronous reset to RESET_VAL, single write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r*DATA_W +: DATA_W] <= RESET_VAL;
         end
      end else if (we) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (waddr == ADDR_W'(r)) begin
               regs_q[r*DATA_W +: DATA_W] <= wdata;
            end
         end
      end
   end

   // Read mux; unimplemented addresses read as zero.
   always_comb begin
      rdata = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (raddr == ADDR_W'(r)) begin
            rdata = regs_q[r*DATA_W +: DATA_W];
         end
      end
   end

   assign regs_flat = regs_q;

endmodule

// File: rtl/spi_3wire_slave_regmap_param.sv
// 3-wire SPI slave (shared data pin) in front of a parametrised register map.
// Frame: rnw bit, ADDR_W address bits, then data words with auto-increment and wrap.
// Optional feature macro: SPI3W_PARITY_EN (even parity bit after each data word, sticky par_err).
module spi_3wire_slave_regmap_param
   import spi3w_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 7,
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       NUM_REGS  = 2 ** ADDR_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       sclk,
   input  logic                       reset,
   input  logic                       ss_n,
   inout  wire                        sdata,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       par_err
);

   localparam int unsigned WORD_W  = word_len(DATA_W);
   localparam int unsigned MAX_LEN = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
   localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   spi3w_state_t        state_q;
   logic                rnw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [WORD_W-2:0]   shreg_q;
   logic [WORD_W-1:0]   rd_shreg_q;
   logic                sdata_oe_q;
   logic                sdata_out_q;
   logic                wr_pulse_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   // Set by reset; keeps the rest of an interrupted frame from being decoded.
   logic                hold_q;

   logic                in_range;
   logic [ADDR_W-1:0]   addr_inc;
   logic                addr_last;
   logic                word_last;
   logic [DATA_W-1:0]   wdata_word;
   logic                par_ok;
   logic                active;
   logic                commit;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic [WORD_W-1:0]   rd_word;

   assign in_range  = (32'(addr_q) < NUM_REGS);
   assign addr_inc  = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + ADDR_W'(1);
   assign addr_last = (bit_cnt_q == CNT_W'(ADDR_W - 1));
   assign word_last = (bit_cnt_q == CNT_W'(WORD_W - 1));
   assign active    = ~ss_n & ~hold_q;

   // Assemble the incoming word and check its parity when enabled.
   always_comb begin
`ifdef SPI3W_PARITY_EN
      wdata_word = shreg_q;
      par_ok     = ~(^shreg_q ^ sdata);
      rd_word    = {rd_data, ^rd_data};
`else
      wdata_word = {shreg_q, sdata};
      par_ok     = 1'b1;
      rd_word    = rd_data;
`endif
   end

   // Write strobe to the register file and read-port address selection.
   always_comb begin
      commit  = active && (state_q == ST_WDATA) && word_last && par_ok && in_range;
      // During read data the port prefetches the next word so it follows without a gap.
      rd_addr = (state_q == ST_RDATA) ? addr_inc : addr_q;
   end

   spi3w_regfile #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk       (sclk),
      .reset     (reset),
      .we        (commit),
      .waddr     (addr_q),
      .wdata     (wdata_word),
      .raddr     (rd_addr),
      .rdata     (rd_data),
      .regs_flat (regs_flat)
   );

   // Frame sequencer: command, address, then write or turnaround/read words.
   always_ff @(posedge sclk) begin
      wr_pulse_q <= 1'b0;
      if (reset) begin
         state_q     <= ST_CMD;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         rd_shreg_q  <= '0;
         sdata_oe_q  <= 1'b0;
         sdata_out_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         hold_q      <= 1'b1;
      end else if (ss_n) begin
         state_q    <= ST_CMD;
         bit_cnt_q  <= '0;
         sdata_oe_q <= 1'b0;
         hold_q     <= 1'b0;
      end else if (!hold_q) begin
         unique case (state_q)
            ST_CMD: begin
               rnw_q     <= sdata;
               bit_cnt_q <= '0;
               state_q   <= ST_ADDR;
            end
            ST_ADDR: begin
               addr_q <= ADDR_W'({addr_q, sdata});
               if (addr_last) begin
                  bit_cnt_q <= '0;
                  state_q   <= rnw_q ? ST_TURN : ST_WDATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               end
            end
            ST_WDATA: begin
               shreg_q <= (WORD_W-1)'({shreg_q, sdata});
               if (word_last) begin
                  bit_cnt_q <= '0;
                  if (par_ok) begin
                     addr_q <= addr_inc;
                  end
                  if (commit) begin
                     wr_pulse_q <= 1'b1;
                     wr_addr_q  <= addr_q;
                     wr_data_q  <= wdata_word;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               end
            end
            ST_TURN: begin
               sdata_oe_q <= 1'b1;
               rd_shreg_q <= rd_word;
               bit_cnt_q  <= '0;
               state_q    <= ST_RDATA;
            end
            ST_RDATA: begin
               sdata_out_q <= rd_shreg_q[WORD_W-1];
               if (word_last) begin
                  rd_shreg_q <= rd_word;
                  addr_q     <= addr_inc;
                  bit_cnt_q  <= '0;
               end else begin
                  rd_shreg_q <= WORD_W'({rd_shreg_q, 1'b0});
                  bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_CMD;
         endcase
      end
   end

`ifdef SPI3W_PARITY_EN
   logic par_err_q;

   // Sticky parity error on any bad write word; cleared only by reset.
   always_ff @(posedge sclk) begin
      if (reset) begin
         par_err_q <= 1'b0;
      end else if (active && (state_q == ST_WDATA) && word_last && !par_ok) begin
         par_err_q <= 1'b1;
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   // Release the pad combinationally as soon as chip select drops away.
   assign sdata    = (sdata_oe_q & ~ss_n) ? sdata_out_q : 1'bz;

   assign wr_pulse = wr_pulse_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_3wire_slave_regmap_param.sv
// Directed bench for the 3-wire SPI slave register map (NUM_REGS=16, ADDR_W=7, DATA_W=8).
// Honours SPI3W_PARITY_EN by adding parity bits to the host frames.
module tb_spi_3wire_slave_regmap_param;
   import spi3w_pkg::*;

   localparam int WL = word_len(8);

   logic         sclk = 1'b0;
   logic         reset = 1'b1;
   logic         ss_n = 1'b1;
   logic         host_oe = 1'b0;
   logic         host_out = 1'b0;
   wire          sdata;
   logic [127:0] regs_flat;
   logic         wr_pulse;
   logic [6:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         par_err;

   int           n_vec = 0;
   int           n_err = 0;
   int           pulse_cnt = 0;
   logic [6:0]   pulse_addr [8];
   logic [7:0]   pulse_data [8];
   logic [7:0]   exp_regs [16];
   logic [15:0]  rd_val;
   logic [7:0]   rd_byte;

   assign sdata = host_oe ? host_out : 1'bz;

   always #5 sclk = ~sclk;

   spi_3wire_slave_regmap_param #(
      .ADDR_W    (7),
      .DATA_W    (8),
      .NUM_REGS  (16),
      .RESET_VAL (8'h00)
   ) dut (
      .sclk      (sclk),
      .reset     (reset),
      .ss_n      (ss_n),
      .sdata     (sdata),
      .regs_flat (regs_flat),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .par_err   (par_err)
   );

   // Log every committed write strobe.
   always @(negedge sclk) begin
      if (wr_pulse) begin
         if (pulse_cnt < 8) begin
            pulse_addr[pulse_cnt] = wr_addr;
            pulse_data[pulse_cnt] = wr_data;
         end
         pulse_cnt = pulse_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_flat();
      logic [127:0] f;
      for (int r = 0; r < 16; r++) f[r*8 +: 8] = exp_regs[r];
      return f;
   endfunction

   task automatic start_frame(input logic rnw);
      @(negedge sclk);
      ss_n = 1'b0; host_oe = 1'b1; host_out = rnw;
      pulse_cnt = 0;
   endtask

   task automatic put_bit(input logic b);
      @(negedge sclk);
      host_out = b;
   endtask

   task automatic put_addr(input logic [6:0] a);
      for (int i = 6; i >= 0; i--) put_bit(a[i]);
   endtask

   task automatic put_word(input logic [7:0] d, input logic flip);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
`ifdef SPI3W_PARITY_EN
      put_bit(^d ^ flip);
`else
      if (flip) $display("note: parity flip ignored without parity");
`endif
   endtask

   // Raise ss_n, then let the idle edge and strobe monitor settle.
   task automatic end_frame();
      @(negedge sclk);
      ss_n = 1'b1; host_oe = 1'b0; host_out = 1'b0;
      @(posedge sclk);
      #1;
   endtask

   task automatic get_word(output logic [7:0] d);
      logic [8:0] sh;
      sh = '0;
      for (int i = 0; i < WL; i++) begin
         @(negedge sclk);
         sh = {sh[7:0], sdata};
      end
`ifdef SPI3W_PARITY_EN
      d = sh[8:1];
      check("rd_parity", 128'(sh[0]), 128'(^sh[8:1]));
`else
      d = sh[7:0];
`endif
   endtask

   // Read frame: release bus before turnaround, skip the turnaround cycle, then sample.
   task automatic read_frame(input logic [6:0] a, input int n, output logic [15:0] v);
      logic [7:0] b;
      v = '0;
      start_frame(1'b1);
      put_addr(a);
      @(negedge sclk);
      host_oe = 1'b0;
      @(negedge sclk);
      for (int w = 0; w < n; w++) begin
         get_word(b);
         v = {v[7:0], b};
      end
      end_frame();
   endtask

   initial begin
      for (int r = 0; r < 16; r++) exp_regs[r] = 8'h00;
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      reset = 1'b0;
      @(posedge sclk);
      #1;
      check("reset_regs", regs_flat, exp_flat());
      check("reset_wr_pulse", 128'(wr_pulse), 128'(0));
      check("reset_wr_addr", 128'(wr_addr), 128'(0));
      check("reset_wr_data", 128'(wr_data), 128'(0));
      check("reset_par_err", 128'(par_err), 128'(0));

      // Burst write 05: A5, 3C.
      start_frame(1'b0);
      put_addr(7'h05);
      put_word(8'hA5, 1'b0);
      put_word(8'h3C, 1'b0);
      end_frame();
      exp_regs[5] = 8'hA5; exp_regs[6] = 8'h3C;
      check("burst_pulse_cnt", 128'(pulse_cnt), 128'(2));
      check("burst_addr0", 128'(pulse_addr[0]), 128'(7'h05));
      check("burst_data0", 128'(pulse_data[0]), 128'(8'hA5));
      check("burst_addr1", 128'(pulse_addr[1]), 128'(7'h06));
      check("burst_data1", 128'(pulse_data[1]), 128'(8'h3C));
      check("burst_regs", regs_flat, exp_flat());

      // Burst read 05, two words back to back.
      read_frame(7'h05, 2, rd_val);
      check("burst_read", 128'(rd_val), 128'(16'hA53C));

      // Wrap: 0F then 00.
      start_frame(1'b0);
      put_addr(7'h0F);
      put_word(8'h11, 1'b0);
      put_word(8'h22, 1'b0);
      end_frame();
      exp_regs[15] = 8'h11; exp_regs[0] = 8'h22;
      check("wrap_pulse_cnt", 128'(pulse_cnt), 128'(2));
      check("wrap_addr1", 128'(pulse_addr[1]), 128'(7'h00));
      check("wrap_regs", regs_flat, exp_flat());
      read_frame(7'h0F, 2, rd_val);
      check("wrap_read", 128'(rd_val), 128'(16'h1122));

      // Out of range write and read.
      start_frame(1'b0);
      put_addr(7'h20);
      put_word(8'hFF, 1'b0);
      end_frame();
      check("oor_pulse_cnt", 128'(pulse_cnt), 128'(0));
      check("oor_regs", regs_flat, exp_flat());
      read_frame(7'h20, 1, rd_val);
      check("oor_read", 128'(rd_val), 128'(16'h0000));

      // Abort after 4 data bits, then a good frame.
      start_frame(1'b0);
      put_addr(7'h03);
      for (int i = 7; i >= 4; i--) put_bit(1'b1);
      end_frame();
      check("abort_pulse_cnt", 128'(pulse_cnt), 128'(0));
      check("abort_regs", regs_flat, exp_flat());
      start_frame(1'b0);
      put_addr(7'h03);
      put_word(8'h5A, 1'b0);
      end_frame();
      exp_regs[3] = 8'h5A;
      check("after_abort_pulse_cnt", 128'(pulse_cnt), 128'(1));
      check("after_abort_regs", regs_flat, exp_flat());
      read_frame(7'h03, 1, rd_val);
      check("after_abort_read", 128'(rd_val), 128'(16'h005A));

      // Reset in mid-frame: rest of frame ignored, all registers cleared.
      start_frame(1'b0);
      put_addr(7'h02);
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
      @(negedge sclk);
      reset = 1'b1; host_out = 1'b1;
      @(negedge sclk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) put_bit(1'b1);
      end_frame();
      for (int r = 0; r < 16; r++) exp_regs[r] = 8'h00;
      check("midreset_pulse_cnt", 128'(pulse_cnt), 128'(0));
      check("midreset_regs", regs_flat, exp_flat());
      start_frame(1'b0);
      put_addr(7'h01);
      put_word(8'h42, 1'b0);
      end_frame();
      exp_regs[1] = 8'h42;
      check("post_reset_pulse_cnt", 128'(pulse_cnt), 128'(1));
      check("post_reset_regs", regs_flat, exp_flat());
      check("no_par_err", 128'(par_err), 128'(0));

`ifdef SPI3W_PARITY_EN
      // Bad parity: dropped, sticky error; then good parity commits.
      start_frame(1'b0);
      put_addr(7'h01);
      put_word(8'h03, 1'b1);
      end_frame();
      check("par_bad_pulse_cnt", 128'(pulse_cnt), 128'(0));
      check("par_bad_err", 128'(par_err), 128'(1));
      check("par_bad_regs", regs_flat, exp_flat());
      start_frame(1'b0);
      put_addr(7'h01);
      put_word(8'h03, 1'b0);
      end_frame();
      exp_regs[1] = 8'h03;
      check("par_good_pulse_cnt", 128'(pulse_cnt), 128'(1));
      check("par_good_regs", regs_flat, exp_flat());
      check("par_err_sticky", 128'(par_err), 128'(1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
